// File: rtl/am_modulator_pkg.sv
// Shared constants and helpers for the AM modulator slice.
package am_modulator_pkg;

   localparam int AUDIO_W_DEF   = 12;
   localparam int CARRIER_W_DEF = 8;
   localparam int ACC_W         = 23;
   localparam logic signed [ACC_W-1:0] FS = 23'sd524288;

   // True when adding step to addr leaves the 16-entry table, including the
   // degenerate step-of-zero case parked on the last entry.
   function automatic logic phase_wrap(input logic [3:0] addr, input logic [3:0] step);
      logic [4:0] sum;
      sum = {1'b0, addr} + {1'b0, step};
      return sum[4] | ((step == 4'd0) & (addr == 4'd15));
   endfunction

endpackage

// File: rtl/sd_mod1.sv
// First-order sigma-delta modulator: one accumulator, one comparator.
module sd_mod1
   import am_modulator_pkg::*;
#(
   parameter int PROD_W = 21
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid,
   input  logic signed [PROD_W-1:0] prod,
   output logic                     dout
);

   logic signed [ACC_W-1:0] acc_r;
   logic signed [ACC_W-1:0] acc_next_s;
   logic signed [ACC_W-1:0] prod_ext_s;
   logic signed [ACC_W-1:0] fb_s;
   logic                    dout_r;

   // Next accumulator value: integrate the product minus the fed-back output level.
   always_comb begin
      prod_ext_s = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      fb_s       = dout_r ? FS : -FS;
      acc_next_s = acc_r + prod_ext_s - fb_s;
   end

   // Accumulator and output bit advance only on valid products; otherwise they hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_r  <= '0;
         dout_r <= 1'b0;
      end else if (valid) begin
         acc_r  <= acc_next_s;
         dout_r <= ~acc_next_s[ACC_W-1];
      end else begin
         acc_r  <= acc_r;
         dout_r <= dout_r;
      end
   end

   assign dout = dout_r;

endmodule

// File: rtl/am_modulator.sv
// AM modulator: phase accumulator for an external cosine table, one-entry audio
// buffer consumed once per carrier period, product stage and 1-bit sigma-delta output.
module am_modulator
   import am_modulator_pkg::*;
#(
   parameter int AUDIO_W   = AUDIO_W_DEF,
   parameter int CARRIER_W = CARRIER_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [3:0]                  phase_step,
   output logic [3:0]                  phase_addr,
   input  logic signed [CARRIER_W-1:0] carrier_in,
   input  logic signed [AUDIO_W-1:0]   audio_in,
   input  logic                        audio_valid,
   output logic                        audio_ready,
   input  logic [1:0]                  depth_shift,
   input  logic                        clear_status,
   output logic                        underrun,
   output logic                        dout
);

   localparam int PROD_W = CARRIER_W + AUDIO_W + 1;
   localparam logic [AUDIO_W-1:0] MID = {1'b1, {(AUDIO_W-1){1'b0}}};

   logic [3:0]                phase_r;
   logic                      wrap_s;
   logic                      ready_s;
   logic                      capture_s;
   logic signed [AUDIO_W-1:0] hold_r;
   logic                      hold_full_r;
   logic signed [AUDIO_W-1:0] shifted_s;
   logic [AUDIO_W-1:0]        env_next_s;
   logic [AUDIO_W-1:0]        env_r;
   logic                      underrun_r;
   logic                      v_addr_r;
   logic                      v_car_r;
   logic                      v_prod_r;
   logic signed [PROD_W-1:0]  prod_s;
   logic signed [PROD_W-1:0]  prod_r;

   // Wrap detection, handshake and the offset-binary envelope candidate.
   always_comb begin
      wrap_s     = en & phase_wrap(phase_r, phase_step);
      ready_s    = rst_n & (~hold_full_r | wrap_s);
      capture_s  = audio_valid & ready_s;
      shifted_s  = hold_r >>> depth_shift;
      env_next_s = $unsigned(shifted_s) + MID;
      prod_s     = PROD_W'(carrier_in) * PROD_W'($signed({1'b0, env_r}));
   end

   // Phase accumulator and the valid bits that follow each address through the table and multiplier.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_r  <= 4'd0;
         v_addr_r <= 1'b0;
         v_car_r  <= 1'b0;
         v_prod_r <= 1'b0;
      end else begin
         phase_r  <= en ? (phase_r + phase_step) : phase_r;
         v_addr_r <= en;
         v_car_r  <= v_addr_r & en;
         v_prod_r <= v_car_r & en;
      end
   end

   // Holding register, envelope load on wrap, and the sticky underrun flag (set beats clear).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_r      <= '0;
         hold_full_r <= 1'b0;
         env_r       <= MID;
         underrun_r  <= 1'b0;
      end else begin
         hold_r <= capture_s ? audio_in : hold_r;
         if (capture_s) begin
            hold_full_r <= 1'b1;
         end else if (wrap_s) begin
            hold_full_r <= 1'b0;
         end else begin
            hold_full_r <= hold_full_r;
         end
         env_r <= (wrap_s && hold_full_r) ? env_next_s : env_r;
         if (wrap_s && !hold_full_r) begin
            underrun_r <= 1'b1;
         end else if (clear_status) begin
            underrun_r <= 1'b0;
         end else begin
            underrun_r <= underrun_r;
         end
      end
   end

   // Registered carrier-times-envelope product.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod_r <= '0;
      end else begin
         prod_r <= en ? prod_s : prod_r;
      end
   end

   sd_mod1 #(
      .PROD_W (PROD_W)
   ) u_sd_mod1 (
      .clk   (clk),
      .rst_n (rst_n),
      .valid (v_prod_r & en),
      .prod  (prod_r),
      .dout  (dout)
   );

   assign phase_addr  = phase_r;
   assign audio_ready = ready_s;
   assign underrun    = underrun_r;

endmodule

// File: tb/tb_am_modulator.sv
// Self-checking bench for am_modulator with a registered cosine table model.
module tb_am_modulator;

   logic              clk;
   logic              rst_n;
   logic              en;
   logic [3:0]        phase_step;
   logic [3:0]        phase_addr;
   logic signed [7:0] carrier_in;
   logic signed [11:0] audio_in;
   logic              audio_valid;
   logic              audio_ready;
   logic [1:0]        depth_shift;
   logic              clear_status;
   logic              underrun;
   logic              dout;

   int total = 0;
   int bad   = 0;

   logic signed [7:0] cos_tab [16] = '{8'sd127, 8'sd117, 8'sd90, 8'sd49, 8'sd0, -8'sd49, -8'sd90, -8'sd117,
                                       -8'sd127, -8'sd117, -8'sd90, -8'sd49, 8'sd0, 8'sd49, 8'sd90, 8'sd117};

   typedef struct {
      logic       en;
      logic [3:0] step;
      logic       exp_ready;
      logic [3:0] exp_addr;
   } phase_vec_t;

   typedef struct {
      logic signed [11:0] audio;
      logic [1:0]         depth;
      int                 exp_env;
      int                 addr;
   } env_vec_t;

   phase_vec_t pv [13];
   env_vec_t   ev [6];
   logic [3:0] sb_q [$];

   am_modulator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .phase_step   (phase_step),
      .phase_addr   (phase_addr),
      .carrier_in   (carrier_in),
      .audio_in     (audio_in),
      .audio_valid  (audio_valid),
      .audio_ready  (audio_ready),
      .depth_shift  (depth_shift),
      .clear_status (clear_status),
      .underrun     (underrun),
      .dout         (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External cosine ROM: data appears one cycle after its address.
   always @(posedge clk) carrier_in <= cos_tab[phase_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; audio_valid = 1'b0; clear_status = 1'b0;
      phase_step = 4'd0; depth_shift = 2'd0; audio_in = '0;
      tick();
      rst_n = 1'b1;
   endtask

   // Capture one sample from an empty buffer, then wrap to consume it into env.
   task automatic load_env(input logic signed [11:0] a, input logic [1:0] d);
      en = 1'b1; phase_step = 4'd8; audio_valid = 1'b1; audio_in = a; depth_shift = d;
      tick();
      tick();
      audio_valid = 1'b0;
   endtask

   // Count dout ones over n enabled cycles and compare against the ideal duty.
   task automatic duty_check(input string name, input int n, input longint prod);
      int     ones;
      longint exp;
      longint diff;
      ones = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         ones += int'(dout);
      end
      exp  = (longint'(n) * (64'sd524288 + prod)) / 64'sd1048576;
      diff = longint'(ones) - exp;
      total++;
      if (diff > 3 || diff < -3) begin
         bad++;
         $display("FAIL %s: got ones=%0d want %0d +/-3", name, ones, exp);
      end
   endtask

   initial begin
      pv[0]  = '{1'b1, 4'd3,  1'b1, 4'd3};
      pv[1]  = '{1'b1, 4'd3,  1'b0, 4'd6};
      pv[2]  = '{1'b1, 4'd3,  1'b0, 4'd9};
      pv[3]  = '{1'b1, 4'd3,  1'b0, 4'd12};
      pv[4]  = '{1'b1, 4'd3,  1'b0, 4'd15};
      pv[5]  = '{1'b1, 4'd3,  1'b1, 4'd2};
      pv[6]  = '{1'b0, 4'd5,  1'b0, 4'd2};
      pv[7]  = '{1'b1, 4'd0,  1'b0, 4'd2};
      pv[8]  = '{1'b1, 4'd13, 1'b0, 4'd15};
      pv[9]  = '{1'b1, 4'd0,  1'b1, 4'd15};
      pv[10] = '{1'b1, 4'd1,  1'b1, 4'd0};
      pv[11] = '{1'b1, 4'd15, 1'b0, 4'd15};
      pv[12] = '{1'b1, 4'd1,  1'b1, 4'd0};

      ev[0] = '{-12'sd2048, 2'd0, 0,    0};
      ev[1] = '{12'sd2047,  2'd2, 2559, 0};
      ev[2] = '{12'sd1024,  2'd0, 3072, 8};
      ev[3] = '{-12'sd1,    2'd1, 2047, 0};
      ev[4] = '{-12'sd2048, 2'd3, 1792, 8};
      ev[5] = '{12'sd2047,  2'd0, 4095, 0};

      // Reset state
      rst_n = 1'b0; en = 1'b1; phase_step = 4'd5; audio_valid = 1'b1; audio_in = 12'sh400;
      depth_shift = 2'd0; clear_status = 1'b0;
      #1;
      chk("ready_in_reset", audio_ready, 1'b0);
      tick();
      tick();
      chk("rst_addr", phase_addr, 4'd0);
      chk("rst_dout", dout, 1'b0);
      chk("rst_underrun", underrun, 1'b0);
      chk("rst_env", dut.env_r, 2048);

      // Phase sequence and handshake with audio_valid held high at 0x400
      rst_n = 1'b1; audio_valid = 1'b1; audio_in = 12'sh400;
      for (int i = 0; i < 13; i++) begin
         en = pv[i].en; phase_step = pv[i].step;
         sb_q.push_back(pv[i].exp_addr);
         #1;
         chk($sformatf("ready[%0d]", i), audio_ready, pv[i].exp_ready);
         tick();
         chk($sformatf("addr[%0d]", i), phase_addr, sb_q.pop_front());
         if (i == 5) chk("env_0x400", dut.env_r, 3072);
      end
      chk("no_underrun_phase", underrun, 1'b0);

      // Envelope loads followed by steady-carrier duty checks
      for (int i = 0; i < 6; i++) begin
         do_reset();
         load_env(ev[i].audio, ev[i].depth);
         chk($sformatf("env[%0d]", i), dut.env_r, ev[i].exp_env);
         en = 1'b1;
         if (ev[i].addr == 8) begin
            phase_step = 4'd8;
            tick();
         end
         phase_step = 4'd0;
         for (int k = 0; k < 6; k++) tick();
         chk($sformatf("hold_addr[%0d]", i), phase_addr, ev[i].addr);
         duty_check($sformatf("duty[%0d]", i), 1024, longint'(cos_tab[ev[i].addr]) * longint'(ev[i].exp_env));
      end

      // Underrun set, clear, and set-beats-clear
      do_reset();
      en = 1'b1; phase_step = 4'd8;
      tick();
      chk("urun_before_wrap", underrun, 1'b0);
      tick();
      chk("urun_set", underrun, 1'b1);
      chk("urun_env_hold", dut.env_r, 2048);
      en = 1'b0; clear_status = 1'b1;
      tick();
      chk("urun_clear", underrun, 1'b0);
      en = 1'b1;
      tick();
      chk("urun_clear_nowrap", underrun, 1'b0);
      tick();
      chk("urun_set_wins", underrun, 1'b1);
      clear_status = 1'b0;

      // Tone over whole carrier periods, then a reset pulse mid-run
      do_reset();
      load_env(12'sh400, 2'd0);
      audio_valid = 1'b1; phase_step = 4'd1;
      for (int k = 0; k < 6; k++) tick();
      duty_check("duty_tone", 1024, 0);
      chk("tone_no_underrun", underrun, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("ready_mid_reset", audio_ready, 1'b0);
      tick();
      chk("mid_rst_addr", phase_addr, 4'd0);
      chk("mid_rst_dout", dout, 1'b0);
      chk("mid_rst_env", dut.env_r, 2048);
      rst_n = 1'b1; en = 1'b0; audio_valid = 1'b0;
      #1;
      chk("mid_rst_empty", audio_ready, 1'b1);
      tick();
      chk("mid_rst_underrun", underrun, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
